// File: rtl/jx2_mem_tile_resp.sv
// jx2_mem_tile_resp
//   Memory-side responder for the 128-bit memPc line bus driven by the
//   data-cache tile. Line reads and write-backs are served from an internal
//   line RAM after a programmable HOLD latency. Requests in the MMIO window
//   (addr[47:45] == 3'b100) are forwarded to a narrow 32-bit MMIO port.
//   Anything else is answered with FAULT.
//
// Ports
//   clock, reset        system clock, synchronous active-low reset
//   memPcAddr[47:0]     request byte address
//   memPcDataO[127:0]   write data from the initiator
//   memPcOpm[4:0]       request opm {WR,OE,Z0,S1,S0}; 0 = no request
//   memPcDataI[127:0]   read data to the initiator
//   memPcOK[1:0]        status: 0 READY, 1 OK, 2 HOLD, 3 FAULT
//   mmioAddr[31:0]      MMIO address
//   mmioDataO[31:0]     MMIO write data
//   mmioOpm[4:0]        MMIO opm; 0 when idle
//   mmioDataI[31:0]     MMIO read data
//   mmioOK[1:0]         MMIO status, same encoding as memPcOK
//
// Build option
//   JX2_MEMRESP_LINEBUF_EN  adds a single-entry last-line buffer. A pure read
//                           that hits it answers OK one cycle after the
//                           request instead of going through the HOLD latency.
module jx2_mem_tile_resp #(
  parameter int LINE_BITS = 10,
  parameter int LAT_CYC   = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [47:0]  memPcAddr,
  input  logic [127:0] memPcDataO,
  input  logic [4:0]   memPcOpm,
  output logic [127:0] memPcDataI,
  output logic [1:0]   memPcOK,
  output logic [31:0]  mmioAddr,
  output logic [31:0]  mmioDataO,
  output logic [4:0]   mmioOpm,
  input  logic [31:0]  mmioDataI,
  input  logic [1:0]   mmioOK
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_OK    = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MMIO = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAT_INIT = 4'(LAT_CYC);

  logic [1:0]           state;
  logic [3:0]           latCnt;
  logic [LINE_BITS-1:0] latIdx;
  logic                 latWr;
  logic                 latRd;
  logic [127:0]         latData;
  logic [127:0]         lineRam [0:(1<<LINE_BITS)-1];

  logic                 isReq;
  logic                 isMmio;
  logic                 isLine;
  logic                 lineDone;
  logic [LINE_BITS-1:0] reqIdx;

`ifdef JX2_MEMRESP_LINEBUF_EN
  logic                 bufValid;
  logic [LINE_BITS-1:0] bufTag;
  logic [127:0]         bufData;
  logic                 bufHit;

  // Only pure reads may short-cut; any write must reach the RAM.
  assign bufHit = bufValid && (bufTag == reqIdx) && memPcOpm[3] && !memPcOpm[4];
`endif

  // Request decode from the current-cycle bus inputs. MMIO takes priority;
  // a line request must have S=111 and no address bits above the RAM.
  always_comb begin
    isReq    = |memPcOpm;
    isMmio   = (memPcAddr[47:45] == 3'b100);
    reqIdx   = memPcAddr[LINE_BITS+3:4];
    isLine   = !isMmio && (memPcOpm[2:0] == 3'b111) &&
               (memPcAddr[47:LINE_BITS+4] == '0);
    // Gated by reset so a write pending when reset hits is never committed.
    lineDone = reset && (state == S_WAIT) && isReq && (latCnt == 4'd1);
  end

  // Control and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      memPcOK    <= ST_READY;
      memPcDataI <= '0;
      mmioOpm    <= '0;
      mmioAddr   <= '0;
      mmioDataO  <= '0;
      latCnt     <= '0;
`ifdef JX2_MEMRESP_LINEBUF_EN
      bufValid   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          memPcOK <= ST_READY;
          if (isReq) begin
            if (isMmio) begin
              state     <= S_MMIO;
              memPcOK   <= ST_HOLD;
              mmioAddr  <= memPcAddr[31:0];
              mmioDataO <= memPcDataO[31:0];
              mmioOpm   <= memPcOpm;
            end else if (isLine) begin
`ifdef JX2_MEMRESP_LINEBUF_EN
              if (bufHit) begin
                state      <= S_DONE;
                memPcOK    <= ST_OK;
                memPcDataI <= bufData;
              end else begin
                state   <= S_WAIT;
                memPcOK <= ST_HOLD;
                latCnt  <= LAT_INIT;
              end
`else
              state   <= S_WAIT;
              memPcOK <= ST_HOLD;
              latCnt  <= LAT_INIT;
`endif
            end else begin
              state   <= S_DONE;
              memPcOK <= ST_FAULT;
            end
          end
        end
        S_WAIT: begin
          if (!isReq) begin
            // Initiator dropped the request: abandon without committing.
            state   <= S_IDLE;
            memPcOK <= ST_READY;
            latCnt  <= '0;
          end else if (lineDone) begin
            // Read-before-write: the RAM read sees the pre-commit contents.
            if (latRd) begin
              memPcDataI <= lineRam[latIdx];
            end
            state   <= S_DONE;
            memPcOK <= ST_OK;
            latCnt  <= '0;
`ifdef JX2_MEMRESP_LINEBUF_EN
            bufValid <= 1'b1;
`endif
          end else begin
            memPcOK <= ST_HOLD;
            latCnt  <= latCnt - 4'd1;
          end
        end
        S_MMIO: begin
          if (!isReq) begin
            state   <= S_IDLE;
            memPcOK <= ST_READY;
            mmioOpm <= '0;
          end else if (mmioOK == ST_OK) begin
            memPcDataI <= {96'h0, mmioDataI};
            memPcOK    <= ST_OK;
            mmioOpm    <= '0;
            state      <= S_DONE;
          end else if (mmioOK == ST_FAULT) begin
            memPcOK <= ST_FAULT;
            mmioOpm <= '0;
            state   <= S_DONE;
          end else begin
            memPcOK <= ST_HOLD;
          end
        end
        S_DONE: begin
          // Status and data stay put until the initiator lets go.
          if (!isReq) begin
            state   <= S_IDLE;
            memPcOK <= ST_READY;
          end
        end
        default: begin
          state   <= S_IDLE;
          memPcOK <= ST_READY;
        end
      endcase
    end
  end

  // Request latch, line RAM and line buffer contents (not reset)
  always_ff @(posedge clock) begin
    if ((state == S_IDLE) && isReq && isLine) begin
      latIdx  <= reqIdx;
      latWr   <= memPcOpm[4];
      latRd   <= memPcOpm[3];
      latData <= memPcDataO;
    end
    if (lineDone && latWr) begin
      lineRam[latIdx] <= latData;
    end
`ifdef JX2_MEMRESP_LINEBUF_EN
    if (lineDone) begin
      bufTag  <= latIdx;
      bufData <= latWr ? latData : lineRam[latIdx];
    end
`endif
  end

endmodule
